// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan decoder: segment patterns (active low,
// bit6=a .. bit0=g), BCD codes, FSM states and a small one-hot helper.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] BCD_BLANK   = 4'hF;
    localparam logic [3:0] BCD_ILLEGAL = 4'hE;

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_SETTLE,
        ST_CAPTURE,
        ST_CHECK
    } state_t;

    function automatic logic is_one_hot(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    function automatic logic [2:0] onehot_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational inverse of the 7-segment driver table: pattern -> BCD nibble,
// with blank mapped to 4'hF and any unknown pattern to 4'hE plus an illegal flag.
module seg7_to_bcd
    import seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_bcd,
    output logic       o_illegal
);

    always_comb begin
        // NOTE: both outputs get a default before the case so no latch is inferred.
        o_bcd     = BCD_ILLEGAL;
        o_illegal = 1'b0;
        case (i_seg)
            SEG_0:     o_bcd = 4'd0;
            SEG_1:     o_bcd = 4'd1;
            SEG_2:     o_bcd = 4'd2;
            SEG_3:     o_bcd = 4'd3;
            SEG_4:     o_bcd = 4'd4;
            SEG_5:     o_bcd = 4'd5;
            SEG_6:     o_bcd = 4'd6;
            SEG_7:     o_bcd = 4'd7;
            SEG_8:     o_bcd = 4'd8;
            SEG_9:     o_bcd = 4'd9;
            SEG_BLANK: o_bcd = BCD_BLANK;
            default:   o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Watches a multiplexed active-low 7-segment scan bus and reassembles the eight
// digits into a 32-bit BCD frame with decimal-point position and health flags.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic        clk_50M,
    input  logic        rst_n,
    input  logic [6:0]  seg_in,
    input  logic        dp_in,
    input  logic [7:0]  an_in,
    output logic [31:0] all_data,
    output logic [2:0]  dp_pos,
    output logic        dp_valid,
    output logic        frame_valid,
    output logic        scan_lost,
    output logic        err
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [6:0]       r_seg_s1, r_seg_s2;
    logic             r_dp_s1, r_dp_s2;
    logic [7:0]       r_an_s1, r_an_s2, r_an_prev;

    state_t           r_state, w_state_nxt;
    logic [3:0]       r_settle_cnt;
    logic [TO_W-1:0]  r_to_cnt;
    logic [7:0][3:0]  r_shadow;
    logic [7:0]       r_seen_mask;
    logic [1:0]       r_dp_cnt;
    logic [2:0]       r_dp_idx;
    logic [2:0]       r_cap_idx;

    logic [31:0]      r_all_data;
    logic [2:0]       r_dp_pos;
    logic             r_dp_valid, r_frame_valid, r_scan_lost, r_err;

    logic [7:0]       w_an_act;
    logic             w_an_change, w_settle_done, w_timeout, w_frame_done, w_err_nxt;
    logic [3:0]       w_bcd;
    logic             w_illegal;

    seg7_to_bcd u_dec (
        .i_seg     (r_seg_s2),
        .o_bcd     (w_bcd),
        .o_illegal (w_illegal)
    );

    assign w_an_act      = ~r_an_s2;
    assign w_an_change   = (r_an_s2 != r_an_prev);
    assign w_settle_done = (r_settle_cnt == 4'd0);
    assign w_timeout     = !w_an_change && (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign w_frame_done  = (r_state == ST_CHECK) && (r_seen_mask == 8'hFF);

    // Synchronizers idle at "everything off" so reset release is not seen as a scan edge.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_s1  <= SEG_BLANK;
            r_seg_s2  <= SEG_BLANK;
            r_dp_s1   <= 1'b1;
            r_dp_s2   <= 1'b1;
            r_an_s1   <= 8'hFF;
            r_an_s2   <= 8'hFF;
            r_an_prev <= 8'hFF;
        end else begin
            // NOTE: non-blocking assignments make each stage take the previous stage's old value.
            r_seg_s1  <= seg_in;
            r_seg_s2  <= r_seg_s1;
            r_dp_s1   <= dp_in;
            r_dp_s2   <= r_dp_s1;
            r_an_s1   <= an_in;
            r_an_s2   <= r_an_s1;
            r_an_prev <= r_an_s2;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) r_state <= ST_WAIT;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_WAIT: begin
                if (w_an_change) w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!w_an_change && w_settle_done) begin
                    if (w_an_act == 8'd0) begin
                        w_state_nxt = ST_WAIT;
                    end else if (!is_one_hot(w_an_act)) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_state_nxt = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                w_err_nxt   = w_illegal;
                w_state_nxt = ST_CHECK;
            end
            ST_CHECK: begin
                w_err_nxt   = w_frame_done && (r_dp_cnt >= 2'd2);
                w_state_nxt = ST_WAIT;
            end
            default: w_state_nxt = ST_WAIT;
        endcase
        if (w_timeout && !w_frame_done) w_state_nxt = ST_WAIT;
    end

    // The shadow is reset to blank so a discarded partial frame can never leak out.
    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_settle_cnt  <= 4'd0;
            r_to_cnt      <= '0;
            r_shadow      <= {8{BCD_BLANK}};
            r_seen_mask   <= 8'd0;
            r_dp_cnt      <= 2'd0;
            r_dp_idx      <= 3'd0;
            r_cap_idx     <= 3'd0;
            r_all_data    <= 32'hFFFF_FFFF;
            r_dp_pos      <= 3'd0;
            r_dp_valid    <= 1'b0;
            r_frame_valid <= 1'b0;
            r_scan_lost   <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_frame_valid <= 1'b0;
            r_err         <= w_err_nxt;

            if (w_an_change)
                r_settle_cnt <= 4'(SETTLE_CYC - 1);
            else if (r_state == ST_SETTLE && !w_settle_done)
                r_settle_cnt <= r_settle_cnt - 4'd1;

            if (w_an_change || w_timeout) r_to_cnt <= '0;
            else                          r_to_cnt <= r_to_cnt + 1'b1;

            if (r_state == ST_SETTLE && w_settle_done)
                r_cap_idx <= onehot_index(w_an_act);

            if (r_state == ST_CAPTURE) begin
                r_shadow[r_cap_idx]    <= w_bcd;
                r_seen_mask[r_cap_idx] <= 1'b1;
                // A repeated digit may refresh its slot but must not inflate the dp count.
                if (!r_dp_s2 && !r_seen_mask[r_cap_idx]) begin
                    r_dp_idx <= r_cap_idx;
                    if (r_dp_cnt != 2'd2) r_dp_cnt <= r_dp_cnt + 2'd1;
                end
            end

            if (w_frame_done) begin
                r_all_data    <= r_shadow;
                r_dp_valid    <= (r_dp_cnt == 2'd1);
                r_dp_pos      <= r_dp_idx;
                r_frame_valid <= 1'b1;
                r_seen_mask   <= 8'd0;
                r_dp_cnt      <= 2'd0;
                r_scan_lost   <= 1'b0;
            end else if (w_timeout) begin
                r_scan_lost   <= 1'b1;
                r_seen_mask   <= 8'd0;
                r_dp_cnt      <= 2'd0;
            end
        end
    end

    assign all_data    = r_all_data;
    assign dp_pos      = r_dp_pos;
    assign dp_valid    = r_dp_valid;
    assign frame_valid = r_frame_valid;
    assign scan_lost   = r_scan_lost;
    assign err         = r_err;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: drives a scan bus digit by digit and checks
// frames, dp reporting, error pulses, timeout and reset behaviour.
module tb_seg_scan_decoder;

    localparam int TIMEOUT = 400;
    localparam int DWELL   = 20;

    logic        clk_50M;
    logic        rst_n;
    logic [6:0]  seg_in;
    logic        dp_in;
    logic [7:0]  an_in;
    logic [31:0] all_data;
    logic [2:0]  dp_pos;
    logic        dp_valid;
    logic        frame_valid;
    logic        scan_lost;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    int fv_total = 0;
    int err_total = 0;
    int fv0, err0;

    seg_scan_decoder #(.SETTLE_CYC(4), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk_50M     (clk_50M),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dp_in       (dp_in),
        .an_in       (an_in),
        .all_data    (all_data),
        .dp_pos      (dp_pos),
        .dp_valid    (dp_valid),
        .frame_valid (frame_valid),
        .scan_lost   (scan_lost),
        .err         (err)
    );

    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    always @(negedge clk_50M) begin
        if (rst_n) begin
            if (frame_valid) fv_total++;
            if (err)         err_total++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Driver table; 4'hE stands for the deliberately illegal pattern 1010101.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b0000001;
            4'd1:    return 7'b1001111;
            4'd2:    return 7'b0010010;
            4'd3:    return 7'b0000110;
            4'd4:    return 7'b1001100;
            4'd5:    return 7'b0100100;
            4'd6:    return 7'b0100000;
            4'd7:    return 7'b0001111;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0000100;
            4'hE:    return 7'b1010101;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic drive(input int idx, input logic [3:0] d, input logic dp_on);
        logic [7:0] sel;
        sel = 8'd1 << idx;
        @(negedge clk_50M);
        an_in  = ~sel;
        seg_in = seg_of(d);
        dp_in  = ~dp_on;
        repeat (DWELL - 1) @(negedge clk_50M);
    endtask

    task automatic scan_part(input logic [31:0] w, input logic [7:0] dpm, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) drive(i, w[4*i +: 4], dpm[i]);
    endtask

    task automatic idle_bus();
        an_in  = 8'hFF;
        seg_in = 7'h7F;
        dp_in  = 1'b1;
    endtask

    task automatic mark();
        fv0  = fv_total;
        err0 = err_total;
    endtask

    initial begin
        idle_bus();
        rst_n = 1'b0;
        repeat (5) @(negedge clk_50M);
        check("rst_all_data", all_data, 32'hFFFF_FFFF);
        check("rst_dp_pos", 32'(dp_pos), 32'd0);
        check("rst_dp_valid", 32'(dp_valid), 32'd0);
        check("rst_frame_valid", 32'(frame_valid), 32'd0);
        check("rst_scan_lost", 32'(scan_lost), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_50M);

        // Reference frame with dp on digit 2
        mark();
        scan_part(32'h0001_2345, 8'b0000_0010, 7, 0);
        check("t1_all_data", all_data, 32'h0001_2345);
        check("t1_dp_pos", 32'(dp_pos), 32'd1);
        check("t1_dp_valid", 32'(dp_valid), 32'd1);
        check("t1_fv_count", 32'(fv_total - fv0), 32'd1);
        check("t1_err_count", 32'(err_total - err0), 32'd0);
        check("t1_scan_lost", 32'(scan_lost), 32'd0);

        // Leading-zero blanking, no dp
        mark();
        scan_part(32'hFFFF_9876, 8'h00, 7, 0);
        check("t2_all_data", all_data, 32'hFFFF_9876);
        check("t2_dp_valid", 32'(dp_valid), 32'd0);
        check("t2_fv_count", 32'(fv_total - fv0), 32'd1);
        check("t2_err_count", 32'(err_total - err0), 32'd0);

        // Illegal pattern on digit 3
        mark();
        scan_part(32'h1234_5E78, 8'h00, 7, 0);
        check("t3_all_data", all_data, 32'h1234_5E78);
        check("t3_err_count", 32'(err_total - err0), 32'd1);
        check("t3_fv_count", 32'(fv_total - fv0), 32'd1);

        // Two decimal points in one frame
        mark();
        scan_part(32'h8765_4321, 8'b1000_0001, 7, 0);
        check("t4_all_data", all_data, 32'h8765_4321);
        check("t4_dp_valid", 32'(dp_valid), 32'd0);
        check("t4_err_count", 32'(err_total - err0), 32'd1);

        // Two digits selected at once, mid-frame
        mark();
        scan_part(32'h1122_3344, 8'b0000_0100, 7, 4);
        @(negedge clk_50M);
        an_in  = 8'b1111_1100;
        seg_in = seg_of(4'd8);
        dp_in  = 1'b1;
        repeat (100) @(negedge clk_50M);
        check("t5_bad_an_err", 32'(err_total - err0), 32'd1);
        check("t5_bad_an_no_fv", 32'(fv_total - fv0), 32'd0);
        check("t5_hold_data", all_data, 32'h8765_4321);
        scan_part(32'h1122_3344, 8'b0000_0100, 3, 0);
        check("t5_fv_count", 32'(fv_total - fv0), 32'd1);
        check("t5_all_data", all_data, 32'h1122_3344);
        check("t5_dp_pos", 32'(dp_pos), 32'd2);
        check("t5_dp_valid", 32'(dp_valid), 32'd1);

        // Repeated digit overwrites its slot, dp counted once
        mark();
        scan_part(32'h5678_9012, 8'b0000_0100, 7, 1);
        drive(2, 4'd3, 1'b1);
        drive(0, 4'd2, 1'b0);
        check("t6_all_data", all_data, 32'h5678_9312);
        check("t6_dp_valid", 32'(dp_valid), 32'd1);
        check("t6_dp_pos", 32'(dp_pos), 32'd2);
        check("t6_fv_count", 32'(fv_total - fv0), 32'd1);
        check("t6_err_count", 32'(err_total - err0), 32'd0);

        // Scan stops after five digits
        mark();
        scan_part(32'h1357_9246, 8'h00, 7, 3);
        repeat (TIMEOUT + 40) @(negedge clk_50M);
        check("t7_scan_lost", 32'(scan_lost), 32'd1);
        check("t7_hold_data", all_data, 32'h5678_9312);
        check("t7_no_fv", 32'(fv_total - fv0), 32'd0);
        scan_part(32'h2468_1357, 8'b0010_0000, 7, 0);
        check("t7_recover_fv", 32'(fv_total - fv0), 32'd1);
        check("t7_recover_lost", 32'(scan_lost), 32'd0);
        check("t7_all_data", all_data, 32'h2468_1357);
        check("t7_dp_pos", 32'(dp_pos), 32'd5);

        // Reset after four captured digits
        scan_part(32'h7777_0000, 8'h00, 7, 4);
        idle_bus();
        rst_n = 1'b0;
        repeat (3) @(negedge clk_50M);
        check("t8_rst_all_data", all_data, 32'hFFFF_FFFF);
        check("t8_rst_dp_pos", 32'(dp_pos), 32'd0);
        check("t8_rst_dp_valid", 32'(dp_valid), 32'd0);
        check("t8_rst_scan_lost", 32'(scan_lost), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_50M);
        mark();
        scan_part(32'h4321_5678, 8'b1000_0000, 3, 0);
        check("t8_partial_no_fv", 32'(fv_total - fv0), 32'd0);
        scan_part(32'h4321_5678, 8'b1000_0000, 7, 4);
        check("t8_fv_count", 32'(fv_total - fv0), 32'd1);
        check("t8_all_data", all_data, 32'h4321_5678);
        check("t8_dp_pos", 32'(dp_pos), 32'd7);
        check("t8_dp_valid", 32'(dp_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
